uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  ASCII command front-end between the UART receiver and card_driver. Collects "W"/"R" + 8 hex addr + 8 hex len + CR/LF,
//  issues one write or read request (strobe held until ACK), then sends a one-byte status reply to the UART TX path.
//  Replaces the single-letter fixed-address command logic in the tester top level.
// PARAMETERS
//  MAX_LEN      32'd65536   largest accepted length in bytes; len==0 or len>MAX_LEN is rejected
//  TIMEOUT_CYC  50_000_000  idle cycles between RX bytes before a partial command is silently dropped (1 s at 50 MHz)
// PORTS
//  CLK        in   1   system clock
//  nRESET     in   1   asynchronous, active-low reset
//  RX_STB     in   1   received byte valid (one-cycle pulse)
//  RX_DAT     in   8   received byte
//  RX_ACK     out  1   byte consumed; combinationally equal to RX_STB (parser never stalls RX)
//  WR_STB     out  1   write request, held until WR_ACK
//  WR_ADDR    out  32  write start address
//  WR_LENGTH  out  32  write length, bytes
//  WR_ACK     in   1   driver accepted write request
//  RD_STB     out  1   read request, held until RD_ACK
//  RD_ADDR    out  32  read start address
//  RD_LENGTH  out  32  read length, bytes
//  RD_ACK     in   1   driver accepted read request
//  TX_STB     out  1   reply byte valid, held until TX_ACK
//  TX_DAT     out  8   reply byte
//  TX_ACK     in   1   UART TX accepted byte
// BEHAVIOUR
//  Reset: all STB outputs 0, ADDR/LENGTH 0, TX_DAT 0, state IDLE, digit counter 0, timeout counter 0.
//  States: IDLE -> ADDR -> LEN -> TERM -> ISSUE -> REPLY -> IDLE.
//   IDLE : "W"/"w" or "R"/"r" latches op, clears shift regs, -> ADDR. CR/LF ignored. Any other byte -> REPLY with 'E'.
//   ADDR : 8 hex digits (0-9,a-f,A-F), MSB first, shifted in as addr <= {addr[27:0],nib}; after 8th -> LEN.
//   LEN  : 8 hex digits, same rule, -> TERM.
//   TERM : CR (8'h0D) or LF (8'h0A) -> validate; len==0 or len>MAX_LEN -> REPLY 'E'; else -> ISSUE.
//   Non-hex in ADDR/LEN or non-CR/LF in TERM -> REPLY 'E' (command discarded, no request issued).
//   ISSUE: assert WR_STB or RD_STB with ADDR/LENGTH from shift regs, first cycle after terminator accepted;
//          hold STB and values stable until matching ACK; STB deasserts the cycle after ACK is seen high; -> REPLY 'K'.
//          ACK arriving on the first STB cycle is valid (one-cycle request).
//   REPLY: TX_STB=1 with TX_DAT; drop STB cycle after TX_ACK; -> IDLE.
//  RX bytes arriving in ISSUE or REPLY are acknowledged and discarded (no reply, no state change).
//  Unsolicited WR_ACK/RD_ACK outside ISSUE are ignored. TX_ACK outside REPLY ignored.
//  Timeout: counter clears on every RX_STB; counts only in ADDR/LEN/TERM; reaching TIMEOUT_CYC-1 -> IDLE, no reply.
//  ADDR/LENGTH outputs retain last issued value between commands; WR_* and RD_* registers are separate.
//  nRESET asserted mid-ISSUE/REPLY: strobes drop immediately (async), request is lost, no reply after release.
// CONFIGURATION
//  UART_CMD_ECHO_EN defined: every byte accepted while in IDLE/ADDR/LEN/TERM is echoed on TX before being parsed;
//   the parser waits in an ECHO sub-state until TX_ACK, RX bytes arriving meanwhile are dropped; status
//   reply follows the echo of the terminator.
//  Not defined: no echo; TX carries only 'K'/'E' replies. Default: not defined.
// STRUCTURE
//  Package uart_cmd_pkg: ASCII constants (CH_W, CH_R, CH_CR, CH_LF, CH_OK='K', CH_ERR='E'), state encoding
//   localparams, digit count constant (8).
//  Sub-module hex_nibble_decode: 8-bit ASCII in -> 4-bit nibble + valid flag, combinational, instantiated once.
//  All counters and FSM in one always block clocked on posedge CLK / negedge nRESET.
// TESTING
//  "W00000001000000C8\r", WR_ACK 3 cycles late -> WR_STB high 4 cycles, WR_ADDR=1, WR_LENGTH=200, then TX 'K'.
//  "r0000ABCD00000010\n", RD_ACK same cycle as STB -> RD_STB 1 cycle, RD_ADDR=32'h0000ABCD, RD_LENGTH=16, 'K'.
//  "W0000G..." -> 'E' on TX at 'G', no WR_STB; following valid "R...\r" is accepted normally.
//  "R0000000100000000\r" (len 0) and len 32'h00010001 -> 'E' each, no RD_STB.
//  "W0000" then 1 s silence (TIMEOUT_CYC=100 in bench) -> back to IDLE, no TX; next full command gives 'K'.
//  nRESET low during ISSUE with STB high -> STB 0 asynchronously, no 'K' after release; with UART_CMD_ECHO_EN,
//   "R..." command bytes echoed in order, then 'K'.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : uart_cmd_pkg                                               |
// | Shared ASCII constants, parser state encoding and small helpers for  |
// | the UART command parser.                                             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_cmd_pkg;

  localparam logic [7:0] CH_W    = 8'h57;  // 'W'
  localparam logic [7:0] CH_W_LC = 8'h77;  // 'w'
  localparam logic [7:0] CH_R    = 8'h52;  // 'R'
  localparam logic [7:0] CH_R_LC = 8'h72;  // 'r'
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] CH_ERR  = 8'h45;  // 'E'

  // Hex digits per field (address and length are both 32 bits)
  localparam int unsigned DIGITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_TERM  = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;
  localparam logic [2:0] ST_REPLY = 3'd5;
  localparam logic [2:0] ST_ECHO  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_LEN   = ST_LEN,
    S_TERM  = ST_TERM,
    S_ISSUE = ST_ISSUE,
    S_REPLY = ST_REPLY,
    S_ECHO  = ST_ECHO
  } state_t;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_write_op(input logic [7:0] b);
    return (b == CH_W) || (b == CH_W_LC);
  endfunction

  function automatic logic is_op(input logic [7:0] b);
    return is_write_op(b) || (b == CH_R) || (b == CH_R_LC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_nibble_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hex_nibble_decode                                          |
// | Combinational ASCII hex digit (0-9, a-f, A-F) to 4-bit nibble with a |
// | valid flag; non-hex input gives nibble 0 and valid 0.                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hex_nibble_decode (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       valid
);

  // Digits carry their value in the low nibble; letters need +9 on top of it
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    if ((ascii >= 8'h30) && (ascii <= 8'h39)) begin
      nibble = ascii[3:0];
      valid  = 1'b1;
    end else if (((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                 ((ascii >= 8'h61) && (ascii <= 8'h66))) begin
      nibble = ascii[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_parser                                            |
// | ASCII "W/R + 8 hex addr + 8 hex len + CR/LF" command front-end.      |
// | Issues one write or read request held until ACK, then replies 'K'   |
// | or 'E' on the TX byte path. Partial commands time out silently.      |
// | Option  : UART_CMD_ECHO_EN echoes every parsed byte before parsing.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [31:0] MAX_LEN     = 32'd65536,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        RX_STB,
  input  logic [7:0]  RX_DAT,
  output logic        RX_ACK,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_LENGTH,
  input  logic        WR_ACK,
  output logic        RD_STB,
  output logic [31:0] RD_ADDR,
  output logic [31:0] RD_LENGTH,
  input  logic        RD_ACK,
  output logic        TX_STB,
  output logic [7:0]  TX_DAT,
  input  logic        TX_ACK
);

  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  DIGIT_LAST = 3'(DIGITS - 1);
`ifdef UART_CMD_ECHO_EN
  // After an echo the TX strobe has just dropped; REPLY raises it again
  localparam logic REPLY_STB_NOW = 1'b0;
`else
  localparam logic REPLY_STB_NOW = 1'b1;
`endif

  state_t      state, state_d;
  logic        op_wr, op_wr_d;
  logic [31:0] addr_sh, addr_sh_d;
  logic [31:0] len_sh, len_sh_d;
  logic [2:0]  digit, digit_d;
  logic [31:0] tmo, tmo_d;
  logic        wr_stb_d, rd_stb_d, tx_stb_d;
  logic [31:0] wr_addr_d, wr_len_d, rd_addr_d, rd_len_d;
  logic [7:0]  tx_dat_d;
  logic        err;

  // Parse event: the byte being interpreted and the state it is interpreted in
  logic        ev_valid;
  logic [7:0]  ev_byte;
  state_t      ev_state;
  logic        in_parse, in_wait;
  logic [3:0]  nib;
  logic        nib_ok;

  assign RX_ACK   = RX_STB;
  assign in_wait  = (state == S_ADDR) || (state == S_LEN) || (state == S_TERM);
  assign in_parse = (state == S_IDLE) || in_wait;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] echo_byte, echo_byte_d;
  state_t     ret_state, ret_state_d;

  assign ev_valid = (state == S_ECHO) && TX_STB && TX_ACK;
  assign ev_byte  = echo_byte;
  assign ev_state = ret_state;
`else
  assign ev_valid = RX_STB && in_parse;
  assign ev_byte  = RX_DAT;
  assign ev_state = state;
`endif

  hex_nibble_decode u_hex (
    .ascii  (ev_byte),
    .nibble (nib),
    .valid  (nib_ok)
  );

  // Next-state logic: timeout, handshakes, then byte parsing (parsing has last word)
  always_comb begin
    state_d   = state;
    op_wr_d   = op_wr;
    addr_sh_d = addr_sh;
    len_sh_d  = len_sh;
    digit_d   = digit;
    tmo_d     = 32'd0;
    wr_stb_d  = WR_STB;
    wr_addr_d = WR_ADDR;
    wr_len_d  = WR_LENGTH;
    rd_stb_d  = RD_STB;
    rd_addr_d = RD_ADDR;
    rd_len_d  = RD_LENGTH;
    tx_stb_d  = TX_STB;
    tx_dat_d  = TX_DAT;
    err       = 1'b0;
`ifdef UART_CMD_ECHO_EN
    echo_byte_d = echo_byte;
    ret_state_d = ret_state;
`endif

    // Inter-byte timeout only runs while a command is partially collected
    if (in_wait) begin
      if (RX_STB) begin
        tmo_d = 32'd0;
      end else if (tmo == TMO_LAST) begin
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo + 32'd1;
      end
    end

    case (state)
      S_ISSUE: begin
        if ((op_wr && WR_ACK) || (!op_wr && RD_ACK)) begin
          wr_stb_d = 1'b0;
          rd_stb_d = 1'b0;
          tx_stb_d = 1'b1;
          tx_dat_d = CH_OK;
          state_d  = S_REPLY;
        end
      end
      S_REPLY: begin
        if (TX_STB) begin
          if (TX_ACK) begin
            tx_stb_d = 1'b0;
            state_d  = S_IDLE;
          end
        end else begin
          tx_stb_d = 1'b1;
        end
      end
`ifdef UART_CMD_ECHO_EN
      S_ECHO: begin
        if (TX_ACK) begin
          tx_stb_d = 1'b0;
          state_d  = ret_state;
        end
      end
      default: begin
        if (RX_STB && in_parse) begin
          echo_byte_d = RX_DAT;
          ret_state_d = state;
          tx_stb_d    = 1'b1;
          tx_dat_d    = RX_DAT;
          state_d     = S_ECHO;
        end
      end
`else
      default: ;
`endif
    endcase

    if (ev_valid) begin
      case (ev_state)
        S_IDLE: begin
          if (is_op(ev_byte)) begin
            op_wr_d   = is_write_op(ev_byte);
            addr_sh_d = 32'd0;
            len_sh_d  = 32'd0;
            digit_d   = 3'd0;
            state_d   = S_ADDR;
          end else if (is_eol(ev_byte)) begin
            state_d = S_IDLE;
          end else begin
            err = 1'b1;
          end
        end
        S_ADDR: begin
          if (nib_ok) begin
            addr_sh_d = {addr_sh[27:0], nib};
            digit_d   = digit + 3'd1;
            state_d   = (digit == DIGIT_LAST) ? S_LEN : S_ADDR;
          end else begin
            err = 1'b1;
          end
        end
        S_LEN: begin
          if (nib_ok) begin
            len_sh_d = {len_sh[27:0], nib};
            digit_d  = digit + 3'd1;
            state_d  = (digit == DIGIT_LAST) ? S_TERM : S_LEN;
          end else begin
            err = 1'b1;
          end
        end
        S_TERM: begin
          if (!is_eol(ev_byte) || (len_sh == 32'd0) || (len_sh > MAX_LEN)) begin
            err = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (op_wr) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_sh;
              wr_len_d  = len_sh;
            end else begin
              rd_stb_d  = 1'b1;
              rd_addr_d = addr_sh;
              rd_len_d  = len_sh;
            end
          end
        end
        default: ;
      endcase
    end

    // A rejected byte discards the command and queues an 'E' reply
    if (err) begin
      state_d  = S_REPLY;
      tx_dat_d = CH_ERR;
      tx_stb_d = REPLY_STB_NOW;
    end
  end

  // All parser registers, counters and outputs; reset drops strobes immediately
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      addr_sh   <= 32'd0;
      len_sh    <= 32'd0;
      digit     <= 3'd0;
      tmo       <= 32'd0;
      WR_STB    <= 1'b0;
      WR_ADDR   <= 32'd0;
      WR_LENGTH <= 32'd0;
      RD_STB    <= 1'b0;
      RD_ADDR   <= 32'd0;
      RD_LENGTH <= 32'd0;
      TX_STB    <= 1'b0;
      TX_DAT    <= 8'd0;
`ifdef UART_CMD_ECHO_EN
      echo_byte <= 8'd0;
      ret_state <= S_IDLE;
`endif
    end else begin
      state     <= state_d;
      op_wr     <= op_wr_d;
      addr_sh   <= addr_sh_d;
      len_sh    <= len_sh_d;
      digit     <= digit_d;
      tmo       <= tmo_d;
      WR_STB    <= wr_stb_d;
      WR_ADDR   <= wr_addr_d;
      WR_LENGTH <= wr_len_d;
      RD_STB    <= rd_stb_d;
      RD_ADDR   <= rd_addr_d;
      RD_LENGTH <= rd_len_d;
      TX_STB    <= tx_stb_d;
      TX_DAT    <= tx_dat_d;
`ifdef UART_CMD_ECHO_EN
      echo_byte <= echo_byte_d;
      ret_state <= ret_state_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_cmd_parser                                         |
// | Scoreboard bench for uart_cmd_parser: command-level reference model  |
// | predicts TX bytes and requests; a monitor compares DUT outputs.      |
// | Option  : UART_CMD_ECHO_EN (echo expectations added when defined).   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_uart_cmd_parser;

  localparam logic [31:0] MAX_LEN = 32'd65536;
  localparam int          TMO     = 100;
`ifdef UART_CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  localparam int K_TX = 0;
  localparam int K_WR = 1;
  localparam int K_RD = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  logic [7:0] cmd_q[$];
  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_dat = 8'd0;
  logic        wr_ack = 1'b0, rd_ack = 1'b0, tx_ack = 1'b0;
  logic        rx_ack, wr_stb, rd_stb, tx_stb;
  logic [31:0] wr_addr, wr_len, rd_addr, rd_len;
  logic [7:0]  tx_dat;

  bit          hold_rd = 1'b0;
  int          forced_dly = -1;
  int          wr_dly = 0, rd_dly = 0;
  logic [31:0] last_wr_addr = 0, last_wr_len = 0, last_rd_addr = 0, last_rd_len = 0;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .nRESET(nrst),
    .RX_STB(rx_stb), .RX_DAT(rx_dat), .RX_ACK(rx_ack),
    .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_LENGTH(wr_len), .WR_ACK(wr_ack),
    .RD_STB(rd_stb), .RD_ADDR(rd_addr), .RD_LENGTH(rd_len), .RD_ACK(rd_ack),
    .TX_STB(tx_stb), .TX_DAT(tx_dat), .TX_ACK(tx_ack)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic see(input int kind, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: got %h/%h expected nothing", name, a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL %s: got kind %0d %h/%h expected kind %0d %h/%h",
                 name, kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: pop on every rising strobe, check request hold time against ACK delay
  initial begin
    logic pw = 0, pr = 0, pt = 0;
    int cw = 0, cr = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        pw = 0; pr = 0; pt = 0; cw = 0; cr = 0;
      end else begin
        if (tx_stb && !pt) see(K_TX, {24'h0, tx_dat}, 32'h0, "tx");
        if (wr_stb && !pw) see(K_WR, wr_addr, wr_len, "wr_req");
        if (rd_stb && !pr) see(K_RD, rd_addr, rd_len, "rd_req");
        if (wr_stb) cw++;
        else if (pw) begin chk("wr_stb_cycles", 32'(cw), 32'(wr_dly + 1)); cw = 0; end
        if (rd_stb) cr++;
        else if (pr) begin chk("rd_stb_cycles", 32'(cr), 32'(rd_dly + 1)); cr = 0; end
        pw = wr_stb; pr = rd_stb; pt = tx_stb;
      end
    end
  end

  // Write-request acknowledger with a per-request delay
  initial begin
    bit busy = 0; int w = 0;
    forever begin
      @(negedge clk);
      if (wr_ack) wr_ack = 1'b0;
      else if (wr_stb) begin
        if (!busy) begin busy = 1; w = (forced_dly >= 0) ? forced_dly : $urandom_range(0, 3); wr_dly = w; end
        if (w == 0) begin wr_ack = 1'b1; busy = 0; end else w--;
      end
    end
  end

  // Read-request acknowledger; can be held off to park the DUT in ISSUE
  initial begin
    bit busy = 0; int w = 0;
    forever begin
      @(negedge clk);
      if (rd_ack) rd_ack = 1'b0;
      else if (rd_stb && !hold_rd) begin
        if (!busy) begin busy = 1; w = (forced_dly >= 0) ? forced_dly : $urandom_range(0, 3); rd_dly = w; end
        if (w == 0) begin rd_ack = 1'b1; busy = 0; end else w--;
      end
    end
  end

  // TX byte acknowledger
  initial begin
    bit busy = 0; int w = 0;
    forever begin
      @(negedge clk);
      if (tx_ack) tx_ack = 1'b0;
      else if (tx_stb) begin
        if (!busy) begin busy = 1; w = $urandom_range(0, 3); end
        if (w == 0) begin tx_ack = 1'b1; busy = 0; end else w--;
      end
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lc);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lc ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dat = b;
    rx_stb = 1'b1;
    #1 chk("rx_ack", {31'h0, rx_ack}, 32'h1);
    @(negedge clk);
    rx_stb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic build_cmd(input bit is_wr, input bit lc, input bit mix,
                           input logic [31:0] addr, input logic [31:0] len);
    cmd_q.delete();
    cmd_q.push_back(is_wr ? (lc ? 8'h77 : 8'h57) : (lc ? 8'h72 : 8'h52));
    for (int i = 0; i < 8; i++) cmd_q.push_back(hexc(addr[31-4*i -: 4], mix ? bit'($urandom_range(0, 1)) : 1'b0));
    for (int i = 0; i < 8; i++) cmd_q.push_back(hexc(len[31-4*i -: 4], mix ? bit'($urandom_range(0, 1)) : 1'b0));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // Send one command; the expected outcome comes from the command fields alone
  task automatic run_cmd(input bit is_wr, input bit lc, input bit mix,
                         input logic [31:0] addr, input logic [31:0] len,
                         input int err_pos, input logic [7:0] bad, input logic [7:0] term,
                         input bit lead, input bit junk);
    bit rejected;
    build_cmd(is_wr, lc, mix, addr, len);
    cmd_q.push_back(term);
    if (err_pos >= 0) begin
      cmd_q[err_pos] = bad;
      while (cmd_q.size() > err_pos + 1) void'(cmd_q.pop_back());
    end
    if (lead) begin
      if (ECHO) push(K_TX, 32'h0A, 0);
      send_byte(8'h0A, $urandom_range(6, 12));
    end
    if (ECHO) foreach (cmd_q[i]) push(K_TX, {24'h0, cmd_q[i]}, 0);
    rejected = (err_pos >= 0) || (len == 0) || (len > MAX_LEN);
    if (rejected) push(K_TX, 32'h45, 0);
    else begin
      push(is_wr ? K_WR : K_RD, addr, len);
      push(K_TX, 32'h4B, 0);
      if (is_wr) begin last_wr_addr = addr; last_wr_len = len; end
      else begin last_rd_addr = addr; last_rd_len = len; end
    end
    foreach (cmd_q[i]) begin
      if (i == cmd_q.size() - 1 && junk) begin
        send_byte(cmd_q[i], 0);
        send_byte(8'h5A, 6);
      end else begin
        send_byte(cmd_q[i], $urandom_range(6, 12));
      end
    end
    wait_drain(600);
    chk("wr_addr_hold", wr_addr, last_wr_addr);
    chk("wr_len_hold", wr_len, last_wr_len);
    chk("rd_addr_hold", rd_addr, last_rd_addr);
    chk("rd_len_hold", rd_len, last_rd_len);
  endtask

  initial begin
    int n;
    logic [7:0] bad_pool[6] = '{8'h47, 8'h5A, 8'h78, 8'h20, 8'h3A, 8'h40};
    logic [31:0] l;

    repeat (3) @(negedge clk);
    chk("rst_wr_stb", {31'h0, wr_stb}, 0);
    chk("rst_rd_stb", {31'h0, rd_stb}, 0);
    chk("rst_tx_stb", {31'h0, tx_stb}, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_len", wr_len, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_tx_dat", {24'h0, tx_dat}, 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // Write, ACK three cycles late -> strobe held four cycles
    forced_dly = 3;
    run_cmd(1, 0, 0, 32'h1, 32'd200, -1, 0, 8'h0D, 0, 0);
    // Lower-case read, ACK on the first strobe cycle
    forced_dly = 0;
    run_cmd(0, 1, 0, 32'h0000ABCD, 32'd16, -1, 0, 8'h0A, 0, 0);
    forced_dly = -1;
    // Non-hex in address, then a valid read
    run_cmd(1, 0, 0, 32'h0, 32'd1, 5, 8'h47, 8'h0D, 0, 0);
    run_cmd(0, 0, 0, 32'h00000010, 32'd4, -1, 0, 8'h0D, 0, 0);
    // Length limits: zero and MAX+1 rejected, exactly MAX accepted
    run_cmd(0, 0, 0, 32'h1, 32'd0, -1, 0, 8'h0D, 0, 0);
    run_cmd(0, 0, 0, 32'h1, 32'h00010001, -1, 0, 8'h0D, 0, 0);
    run_cmd(1, 0, 0, 32'hFFFF_0000, MAX_LEN, -1, 0, 8'h0D, 0, 0);
    // Bad terminator
    run_cmd(1, 0, 0, 32'h2, 32'd2, 17, 8'h20, 8'h0D, 0, 0);

    // Partial command followed by silence drops back to idle with no reply
    build_cmd(1, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (ECHO) push(K_TX, {24'h0, cmd_q[i]}, 0);
      send_byte(cmd_q[i], $urandom_range(6, 12));
    end
    repeat (TMO + 50) @(negedge clk);
    wait_drain(0);
    run_cmd(1, 0, 0, 32'h12345678, 32'd100, -1, 0, 8'h0D, 0, 0);

    // Reset while a read request is pending: strobe drops at once, no reply afterwards
    hold_rd = 1'b1;
    build_cmd(0, 0, 0, 32'h12345678, 32'd8);
    cmd_q.push_back(8'h0D);
    if (ECHO) foreach (cmd_q[i]) push(K_TX, {24'h0, cmd_q[i]}, 0);
    push(K_RD, 32'h12345678, 32'd8);
    foreach (cmd_q[i]) send_byte(cmd_q[i], $urandom_range(6, 12));
    n = 0;
    while (!rd_stb && n < 300) begin @(negedge clk); n++; end
    chk("rd_stb_before_reset", {31'h0, rd_stb}, 1);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("rd_stb_async_reset", {31'h0, rd_stb}, 0);
    chk("tx_stb_async_reset", {31'h0, tx_stb}, 0);
    chk("rd_addr_async_reset", rd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    hold_rd = 1'b0;
    last_wr_addr = 0; last_wr_len = 0; last_rd_addr = 0; last_rd_len = 0;
    repeat (60) @(negedge clk);
    chk("no_reply_after_reset", 32'(sb.size()), 0);
    sb.delete();
    run_cmd(0, 0, 1, 32'hCAFE_F00D, 32'd32, -1, 0, 8'h0D, 0, 0);

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: l = 32'd0;
        1: l = MAX_LEN;
        2: l = MAX_LEN + 32'd1;
        3: l = $urandom_range(1, 65536);
        4: l = $urandom;
        default: l = $urandom_range(1, 255);
      endcase
      run_cmd(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1, $urandom, l,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 17)) : -1,
              bad_pool[$urandom_range(0, 5)],
              $urandom_range(0, 1) ? 8'h0D : 8'h0A,
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
